// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulator control slice:
// default widths and the frame feeder state encoding.
package mac_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        ACC    = 2'd1,
        DRAIN  = 2'd2,
        RESULT = 2'd3
    } mac_feed_state_t;

endpackage

// File: rtl/mac_frame_feeder_if.sv
// Operand-pair stream in and frame-result stream out of the MAC frame feeder.
// The slave modport is the feeder; master is the upstream/downstream side.
interface mac_frame_feeder_if #(
    parameter int DATA_W = mac_pkg::DATA_W,
    parameter int ACC_W  = mac_pkg::ACC_W,
    parameter int CNT_W  = mac_pkg::CNT_W
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              in_last;

    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;
    logic [CNT_W-1:0]  res_count;
    logic              res_ovf;

    modport master (
        output in_valid, in_a, in_b, in_last, res_ready,
        input  in_ready, res_valid, res_data, res_count, res_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, res_ready,
        output in_ready, res_valid, res_data, res_count, res_ovf
    );

endinterface

// File: rtl/mac_frame_feeder.sv
// Frame sequencer in front of the 8x8 MAC: feeds one operand pair per cycle,
// captures the frame sum with count and overflow, then clears the accumulator.
//
// state  | meaning
// CLEAR  | mac_clr asserted, accumulator held at zero, no pairs accepted
// ACC    | accepting pairs, each accepted pair drives data1/data2
// DRAIN  | last product settling into mac_out, then captured
// RESULT | frame result offered downstream until taken
module mac_frame_feeder #(
    parameter int DATA_W = mac_pkg::DATA_W,
    parameter int ACC_W  = mac_pkg::ACC_W,
    parameter int CNT_W  = mac_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              aclr_n,
    mac_frame_feeder_if.slave bus,
    output logic [DATA_W-1:0] mac_data1,
    output logic [DATA_W-1:0] mac_data2,
    output logic              mac_clr,
    input  logic [ACC_W-1:0]  mac_out
);
    import mac_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    mac_feed_state_t  state;
    mac_feed_state_t  state_nxt;

    logic             accept;
    logic             res_hs;
    logic             in_ready_int;
    logic             res_valid_int;
    logic             watch_ovf;
    logic             drain_done;
    logic             drain_cnt;
    logic [ACC_W-1:0] mac_prev;
    logic [ACC_W-1:0] res_data_q;
    logic [CNT_W-1:0] count;
    logic             ovf;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            CLEAR:   state_nxt = ACC;
            ACC:     if (accept && bus.in_last) state_nxt = DRAIN;
            DRAIN:   if (drain_done) state_nxt = RESULT;
            RESULT:  if (res_hs) state_nxt = CLEAR;
            default: state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        in_ready_int  = (state == ACC);
        res_valid_int = (state == RESULT);
        watch_ovf     = (state == ACC) || (state == DRAIN);
        accept        = bus.in_valid && in_ready_int;
        res_hs        = bus.res_ready && res_valid_int;
        drain_done    = (drain_cnt == 1'b0);
    end

    // The last product lands in mac_out one edge after DRAIN entry, so DRAIN
    // waits out that edge and captures on the following one.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            mac_clr    <= 1'b1;
            mac_data1  <= '0;
            mac_data2  <= '0;
            mac_prev   <= '0;
            drain_cnt  <= 1'b0;
            res_data_q <= '0;
            count      <= '0;
            ovf        <= 1'b0;
        end else begin
            mac_clr   <= (state_nxt == CLEAR);
            mac_data1 <= accept ? bus.in_a : '0;
            mac_data2 <= accept ? bus.in_b : '0;
            mac_prev  <= mac_out;
            if (accept && bus.in_last) begin
                drain_cnt <= 1'b1;
            end else if ((state == DRAIN) && !drain_done) begin
                drain_cnt <= drain_cnt - 1'b1;
            end
            if ((state == DRAIN) && drain_done) begin
                res_data_q <= mac_out;
            end
            if (res_hs) begin
                count <= '0;
                ovf   <= 1'b0;
            end else begin
                if (accept && (count != CNT_MAX)) begin
                    count <= count + 1'b1;
                end
                // Unsigned products only add, so any decrease means a wrap.
                if (watch_ovf && (mac_out < mac_prev)) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.res_valid = res_valid_int;
    assign bus.res_data  = res_data_q;
    assign bus.res_count = count;
    assign bus.res_ovf   = ovf;

endmodule
